// File: rtl/cpu_cycle_gen.sv
// 6502 bus-cycle initiator: replays READ/WRITE and LDA/STA (zp),Y cycle sequences.
// Define CYCLE_GEN_BANK_MODEL_EN to model the 6509 $0000/$0001 bank registers.
module cpu_cycle_gen #(
  parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_zp,
  input  logic [7:0]  cmd_y,
  input  logic [7:0]  cmd_data,
  input  logic        rdy,
  output logic [15:0] address_cpu,
  output logic        r_w,
  output logic        sync,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic [3:0]  exp_bank,
  output logic        exp_indirect
);
  typedef enum logic [2:0] {IDLE, OPC, ZPA, PLO, PHI, EFF, FIX, WR} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_LDA, OP_STA} op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [7:0]  zp_q, zp_d, y_q, y_d, wdata_q, wdata_d, pl_q, pl_d, ph_q, ph_d;
  logic [7:0]  dout_q, dout_d, rd_q, rd_d;
  logic [15:0] addr_q, addr_d;
  logic        r_w_q, r_w_d, sync_q, sync_d, oe_q, oe_d, done_q, done_d;
  logic [8:0]  sum;
  logic        adv, last;

  assign sum  = {1'b0, pl_q} + {1'b0, y_q};
  // A read cycle with rdy low repeats; write and idle cycles always move on.
  assign adv  = (state_q == IDLE) || !r_w_q || rdy;
  assign last = (state_q == WR) || (state_q == FIX) ||
                ((state_q == EFF) && ((op_q == OP_READ) || ((op_q == OP_LDA) && !sum[8])));
  assign cmd_ready = (state_q == IDLE) || (last && adv);

  always_comb begin
    // NOTE: every _d gets a hold value first so no path through this block infers a latch.
    state_d = state_q;
    op_d    = op_q;
    zp_d    = zp_q;
    y_d     = y_q;
    wdata_d = wdata_q;
    pl_d    = pl_q;
    ph_d    = ph_q;
    addr_d  = addr_q;
    r_w_d   = r_w_q;
    sync_d  = sync_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    if (adv) begin
      if (state_q == PLO) pl_d = data_in;
      if (state_q == PHI) ph_d = data_in;
      if (last && r_w_q)  rd_d = data_in;
      done_d  = last;
      state_d = IDLE;
      addr_d  = IDLE_ADDR;
      r_w_d   = 1'b1;
      sync_d  = 1'b0;
      oe_d    = 1'b0;
      dout_d  = 8'h00;
      if ((state_q == IDLE) || last) begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          zp_d    = cmd_zp;
          y_d     = cmd_y;
          wdata_d = cmd_data;
          addr_d  = cmd_addr;
          unique case (op_e'(cmd_op))
            OP_READ:  state_d = EFF;
            OP_WRITE: begin
              state_d = WR;
              r_w_d   = 1'b0;
              oe_d    = 1'b1;
              dout_d  = cmd_data;
            end
            default: begin
              state_d = OPC;
              sync_d  = 1'b1;
            end
          endcase
        end
      end else begin
        unique case (state_q)
          OPC: begin state_d = ZPA; addr_d = addr_q + 16'd1;          end
          ZPA: begin state_d = PLO; addr_d = {8'h00, zp_q};           end
          PLO: begin state_d = PHI; addr_d = {8'h00, zp_q + 8'd1};    end
          PHI: begin state_d = EFF; addr_d = {data_in, sum[7:0]};     end
          EFF: begin
            if (op_q == OP_LDA) begin
              state_d = FIX;
              addr_d  = {ph_q + 8'd1, sum[7:0]};
            end else begin
              // STA always writes through the carried page after its dummy read.
              state_d = WR;
              addr_d  = {ph_q + {7'd0, sum[8]}, sum[7:0]};
              r_w_d   = 1'b0;
              oe_d    = 1'b1;
              dout_d  = wdata_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      zp_q    <= 8'h00;
      y_q     <= 8'h00;
      wdata_q <= 8'h00;
      pl_q    <= 8'h00;
      ph_q    <= 8'h00;
      addr_q  <= IDLE_ADDR;
      r_w_q   <= 1'b1;
      sync_q  <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      rd_q    <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      // NOTE: registers update with non-blocking assignments so all see pre-edge values.
      state_q <= state_d;
      op_q    <= op_d;
      zp_q    <= zp_d;
      y_q     <= y_d;
      wdata_q <= wdata_d;
      pl_q    <= pl_d;
      ph_q    <= ph_d;
      addr_q  <= addr_d;
      r_w_q   <= r_w_d;
      sync_q  <= sync_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  assign address_cpu = addr_q;
  assign r_w         = r_w_q;
  assign sync        = sync_q;
  assign data_oe     = oe_q;
  assign data_out    = dout_q;
  assign done        = done_q;
  assign rd_data     = rd_q;

`ifdef CYCLE_GEN_BANK_MODEL_EN
  logic [3:0] sh0_q, sh0_d, sh1_q, sh1_d, bank_q, bank_d;
  logic       ind_q, ind_d;

  always_comb begin
    sh0_d  = sh0_q;
    sh1_d  = sh1_q;
    ind_d  = ind_q;
    bank_d = bank_q;
    if (adv) begin
      if (!r_w_q && (addr_q == 16'h0000)) sh0_d = dout_q[3:0];
      if (!r_w_q && (addr_q == 16'h0001)) sh1_d = dout_q[3:0];
      // Indirect on the INDY EFF cycle and the one after it, unless that is an opcode fetch.
      ind_d  = ((state_d == EFF) && op_d[1]) || ((state_q == EFF) && op_q[1] && !sync_d);
      bank_d = ind_d ? sh1_d : sh0_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sh0_q  <= 4'hF;
      sh1_q  <= 4'hF;
      ind_q  <= 1'b0;
      bank_q <= 4'hF;
    end else begin
      sh0_q  <= sh0_d;
      sh1_q  <= sh1_d;
      ind_q  <= ind_d;
      bank_q <= bank_d;
    end
  end

  assign exp_bank     = bank_q;
  assign exp_indirect = ind_q;
`else
  assign exp_bank     = 4'hF;
  assign exp_indirect = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_cycle_gen.sv
// Directed bench for cpu_cycle_gen: hand-computed bus cycles, stalls, back-to-back and reset abort.
module tb_cpu_cycle_gen;
`ifdef CYCLE_GEN_BANK_MODEL_EN
  localparam bit BANK_EN = 1'b1;
`else
  localparam bit BANK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_zp, cmd_y, cmd_data;
  logic        rdy;
  logic [15:0] address_cpu;
  logic        r_w, sync, data_oe, done, exp_indirect;
  logic [7:0]  data_out, data_in, rd_data;
  logic [3:0]  exp_bank;

  int total = 0;
  int bad   = 0;

  cpu_cycle_gen #(.IDLE_ADDR(16'hFFFF)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_zp(cmd_zp), .cmd_y(cmd_y), .cmd_data(cmd_data),
    .rdy(rdy), .address_cpu(address_cpu), .r_w(r_w), .sync(sync),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .done(done), .rd_data(rd_data), .exp_bank(exp_bank), .exp_indirect(exp_indirect)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic [15:0] a, input logic rw,
                     input logic sy, input logic oe, input logic [7:0] d);
    check({tag, ".addr"}, 32'(address_cpu), 32'(a));
    check({tag, ".r_w"},  32'(r_w),         32'(rw));
    check({tag, ".sync"}, 32'(sync),        32'(sy));
    check({tag, ".oe"},   32'(data_oe),     32'(oe));
    if (oe) check({tag, ".dout"}, 32'(data_out), 32'(d));
  endtask

  task automatic side(input string tag, input logic dn, input logic rd_y, input logic [7:0] rd,
                      input logic [3:0] bk, input logic ind);
    check({tag, ".done"},  32'(done),         32'(dn));
    check({tag, ".ready"}, 32'(cmd_ready),    32'(rd_y));
    check({tag, ".rd"},    32'(rd_data),      32'(rd));
    check({tag, ".bank"},  32'(exp_bank),     32'(bk));
    check({tag, ".ind"},   32'(exp_indirect), 32'(ind));
  endtask

  function automatic logic [3:0] bk(input logic [3:0] v);
    return BANK_EN ? v : 4'hF;
  endfunction

  function automatic logic ind(input logic v);
    return BANK_EN & v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [7:0] zp,
                       input logic [7:0] y, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_zp    = zp;
    cmd_y     = y;
    cmd_data  = d;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 16'h0000;
    cmd_zp = 8'h00; cmd_y = 8'h00; cmd_data = 8'h00; rdy = 1'b1; data_in = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    bus("rst", 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h00);
    check("rst.dout", 32'(data_out), 32'h0);
    side("rst", 1'b0, 1'b1, 8'h00, 4'hF, 1'b0);

    // Two back-to-back writes to the bank registers.
    issue(2'b01, 16'h0000, 8'h00, 8'h00, 8'h03);
    tick();
    bus("w1", 16'h0000, 1'b0, 1'b0, 1'b1, 8'h03);
    side("w1", 1'b0, 1'b1, 8'h00, 4'hF, 1'b0);
    issue(2'b01, 16'h0001, 8'h00, 8'h00, 8'h05);
    tick();
    bus("w2", 16'h0001, 1'b0, 1'b0, 1'b1, 8'h05);
    side("w2", 1'b1, 1'b1, 8'h00, bk(4'h3), 1'b0);
    cmd_valid = 1'b0;
    tick();
    bus("idle1", 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h00);
    side("idle1", 1'b1, 1'b1, 8'h00, bk(4'h3), 1'b0);

    // LDA ($10),Y with Y=4, pointer $1234.
    issue(2'b10, 16'h0200, 8'h10, 8'h04, 8'h00);
    tick();
    bus("l1.opc", 16'h0200, 1'b1, 1'b1, 1'b0, 8'h00);
    side("l1.opc", 1'b0, 1'b0, 8'h00, bk(4'h3), 1'b0);
    cmd_valid = 1'b0; data_in = 8'hB1;
    tick();
    bus("l1.zpa", 16'h0201, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    bus("l1.plo", 16'h0010, 1'b1, 1'b0, 1'b0, 8'h00);
    data_in = 8'h34;
    tick();
    bus("l1.phi", 16'h0011, 1'b1, 1'b0, 1'b0, 8'h00);
    side("l1.phi", 1'b0, 1'b0, 8'h00, bk(4'h3), 1'b0);
    data_in = 8'h12;
    tick();
    bus("l1.eff", 16'h1238, 1'b1, 1'b0, 1'b0, 8'h00);
    side("l1.eff", 1'b0, 1'b1, 8'h00, bk(4'h5), ind(1'b1));
    data_in = 8'h5A;
    tick();
    bus("l1.post", 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h00);
    side("l1.post", 1'b1, 1'b1, 8'h5A, bk(4'h5), ind(1'b1));
    tick();
    side("l1.post2", 1'b0, 1'b1, 8'h5A, bk(4'h3), 1'b0);

    // LDA ($FF),Y with Y=$10, pointer $20F8: pointer wrap and page-crossing FIX.
    issue(2'b10, 16'h0300, 8'hFF, 8'h10, 8'h00);
    tick();
    bus("l2.opc", 16'h0300, 1'b1, 1'b1, 1'b0, 8'h00);
    cmd_valid = 1'b0;
    tick();
    bus("l2.zpa", 16'h0301, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    bus("l2.plo", 16'h00FF, 1'b1, 1'b0, 1'b0, 8'h00);
    data_in = 8'hF8;
    tick();
    bus("l2.phi", 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00);
    data_in = 8'h20;
    tick();
    bus("l2.eff", 16'h2008, 1'b1, 1'b0, 1'b0, 8'h00);
    side("l2.eff", 1'b0, 1'b0, 8'h5A, bk(4'h5), ind(1'b1));
    data_in = 8'h11;
    tick();
    bus("l2.fix", 16'h2108, 1'b1, 1'b0, 1'b0, 8'h00);
    side("l2.fix", 1'b0, 1'b1, 8'h5A, bk(4'h5), ind(1'b1));
    data_in = 8'h77;

    // STA ($20),Y with Y=0, pointer $4000, queued back-to-back; rdy low on WR.
    issue(2'b11, 16'h0400, 8'h20, 8'h00, 8'hAA);
    tick();
    bus("s.opc", 16'h0400, 1'b1, 1'b1, 1'b0, 8'h00);
    side("s.opc", 1'b1, 1'b0, 8'h77, bk(4'h3), 1'b0);
    cmd_valid = 1'b0;
    tick();
    bus("s.zpa", 16'h0401, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    bus("s.plo", 16'h0020, 1'b1, 1'b0, 1'b0, 8'h00);
    data_in = 8'h00;
    tick();
    bus("s.phi", 16'h0021, 1'b1, 1'b0, 1'b0, 8'h00);
    data_in = 8'h40;
    tick();
    bus("s.eff", 16'h4000, 1'b1, 1'b0, 1'b0, 8'h00);
    side("s.eff", 1'b0, 1'b0, 8'h77, bk(4'h5), ind(1'b1));
    tick();
    bus("s.wr", 16'h4000, 1'b0, 1'b0, 1'b1, 8'hAA);
    rdy = 1'b0;
    #1;
    side("s.wr", 1'b0, 1'b1, 8'h77, bk(4'h5), ind(1'b1));
    tick();
    bus("s.post", 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h00);
    side("s.post", 1'b1, 1'b1, 8'h77, bk(4'h3), 1'b0);
    rdy = 1'b1;

    // Single READ whose only cycle stalls once.
    issue(2'b00, 16'hABCD, 8'h00, 8'h00, 8'h00);
    tick();
    bus("rd.c1", 16'hABCD, 1'b1, 1'b0, 1'b0, 8'h00);
    cmd_valid = 1'b0; rdy = 1'b0; data_in = 8'h3C;
    #1;
    side("rd.c1", 1'b0, 1'b0, 8'h77, bk(4'h3), 1'b0);
    tick();
    bus("rd.stall", 16'hABCD, 1'b1, 1'b0, 1'b0, 8'h00);
    side("rd.stall", 1'b0, 1'b0, 8'h77, bk(4'h3), 1'b0);
    rdy = 1'b1;
    #1;
    check("rd.ready", 32'(cmd_ready), 32'h1);
    tick();
    side("rd.post", 1'b1, 1'b1, 8'h3C, bk(4'h3), 1'b0);

    // LDA with rdy low for 3 clocks during PLO, then an LDA queued at its EFF.
    issue(2'b10, 16'h0500, 8'h30, 8'h01, 8'h00);
    tick();
    bus("l3.opc", 16'h0500, 1'b1, 1'b1, 1'b0, 8'h00);
    cmd_valid = 1'b0;
    tick();
    bus("l3.zpa", 16'h0501, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    bus("l3.plo", 16'h0030, 1'b1, 1'b0, 1'b0, 8'h00);
    rdy = 1'b0; data_in = 8'h00;
    tick();
    bus("l3.st1", 16'h0030, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    bus("l3.st2", 16'h0030, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    bus("l3.st3", 16'h0030, 1'b1, 1'b0, 1'b0, 8'h00);
    side("l3.st3", 1'b0, 1'b0, 8'h3C, bk(4'h3), 1'b0);
    rdy = 1'b1;
    tick();
    bus("l3.phi", 16'h0031, 1'b1, 1'b0, 1'b0, 8'h00);
    data_in = 8'h60;
    tick();
    bus("l3.eff", 16'h6001, 1'b1, 1'b0, 1'b0, 8'h00);
    side("l3.eff", 1'b0, 1'b1, 8'h3C, bk(4'h5), ind(1'b1));
    data_in = 8'hC3;
    issue(2'b10, 16'h0600, 8'h40, 8'h00, 8'h00);
    tick();
    bus("l4.opc", 16'h0600, 1'b1, 1'b1, 1'b0, 8'h00);
    side("l4.opc", 1'b1, 1'b0, 8'hC3, bk(4'h3), 1'b0);
    cmd_valid = 1'b0;
    tick();
    tick();
    bus("l4.plo", 16'h0040, 1'b1, 1'b0, 1'b0, 8'h00);
    data_in = 8'h00;
    tick();
    bus("l4.phi", 16'h0041, 1'b1, 1'b0, 1'b0, 8'h00);

    // Reset during PHI aborts the command without a done pulse.
    reset = 1'b1;
    tick();
    bus("abort", 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h00);
    side("abort", 1'b0, 1'b1, 8'h00, 4'hF, 1'b0);
    reset = 1'b0;
    tick();
    bus("abort.post", 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h00);
    side("abort.post", 1'b0, 1'b1, 8'h00, 4'hF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
